// File: rtl/fc_pkg.sv
// Shared constants and state encoding for the FC-layer spike readout path.
package fc_pkg;

  localparam int N_OUT   = 10;
  localparam int CNT_W   = 5;
  localparam int IDX_W   = 4;
  localparam int N_ROWS  = 28;
  localparam int T_STEPS = 20;

  typedef enum logic [1:0] {
    ST_ACC  = 2'd0,
    ST_SCAN = 2'd1,
    ST_OUT  = 2'd2
  } fc_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses and holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != CNT_MAX)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/fc_spike_readout.sv
// Accumulates per-timestep output spikes, picks the argmax class on done's rising
// edge and hands the result downstream.
module fc_spike_readout #(
  parameter int N_OUT = fc_pkg::N_OUT,
  parameter int CNT_W = fc_pkg::CNT_W,
  parameter int IDX_W = fc_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spk_valid,
  input  logic [N_OUT-1:0] spk_vec,
  input  logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_class,
  output logic [CNT_W-1:0] out_count,
  output logic             busy,
  output logic             overrun
);

  import fc_pkg::*;

  // Output handshake: out_valid rises only in OUT and, once high, out_class and
  // out_count hold until the edge where out_valid & out_ready are both 1; that
  // edge is the transfer, which clears the counters and returns to ACC.

  fc_state_t state;
  fc_state_t state_nxt;

  logic                        done_d;
  logic                        done_rise;
  logic                        xfer;
  logic [N_OUT-1:0]            cnt_inc;
  logic [N_OUT-1:0][CNT_W-1:0] cnt;
  logic [IDX_W-1:0]            scan_idx;
  logic                        scan_last;
  logic [CNT_W-1:0]            cnt_sel;
  logic [CNT_W-1:0]            best_cnt;
  logic [IDX_W-1:0]            best_idx;

  assign done_rise = done & ~done_d;
  assign xfer      = (state == ST_OUT) & out_valid & out_ready;
  assign scan_last = (scan_idx == IDX_W'(N_OUT - 1));
  assign busy      = (state != ST_ACC);
  assign cnt_inc   = ((state == ST_ACC) && spk_valid) ? spk_vec : '0;

  for (genvar g = 0; g < N_OUT; g++) begin : g_cnt
    sat_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (xfer),
      .inc (cnt_inc[g]),
      .q   (cnt[g])
    );
  end

  // Compare-select mux keeps the scan index in range without an out-of-bounds select.
  always_comb begin
    cnt_sel = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (scan_idx == IDX_W'(i)) begin
        cnt_sel = cnt[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_ACC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACC:  if (done_rise) state_nxt = ST_SCAN;
      ST_SCAN: if (scan_last) state_nxt = ST_OUT;
      ST_OUT:  if (out_valid && out_ready) state_nxt = ST_ACC;
      default: state_nxt = ST_ACC;
    endcase
  end

  // The first OUT cycle latches the scan winner into the output registers, so
  // out_valid rises one edge after the scan finishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_d    <= 1'b0;
      scan_idx  <= '0;
      best_cnt  <= '0;
      best_idx  <= '0;
      out_valid <= 1'b0;
      out_class <= '0;
      out_count <= '0;
      overrun   <= 1'b0;
    end else begin
      done_d <= done;
      if (spk_valid && (state != ST_ACC)) begin
        overrun <= 1'b1;
      end
      case (state)
        ST_ACC: begin
          scan_idx <= '0;
        end
        ST_SCAN: begin
          scan_idx <= scan_idx + 1'b1;
          if (scan_idx == '0) begin
            best_cnt <= cnt_sel;
            best_idx <= '0;
          end else if (cnt_sel > best_cnt) begin
            best_cnt <= cnt_sel;
            best_idx <= scan_idx;
          end
        end
        ST_OUT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_class <= best_idx;
            out_count <= best_cnt;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          scan_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_spike_readout.sv
// Directed bench for fc_spike_readout: hand-computed winners, latency, backpressure,
// overrun and reset cases checked against an expected-result queue.
module tb_fc_spike_readout;

  localparam int N_OUT = 10;
  localparam int CNT_W = 5;
  localparam int IDX_W = 4;
  localparam int RW    = IDX_W + CNT_W;

  logic             clk;
  logic             rst;
  logic             spk_valid;
  logic [N_OUT-1:0] spk_vec;
  logic             done;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_class;
  logic [CNT_W-1:0] out_count;
  logic             busy;
  logic             overrun;

  int n_checks = 0;
  int n_errors = 0;
  logic [RW-1:0] exp_q[$];

  fc_spike_readout #(
    .N_OUT (N_OUT),
    .CNT_W (CNT_W),
    .IDX_W (IDX_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .spk_valid (spk_valid),
    .spk_vec   (spk_vec),
    .done      (done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_count (out_count),
    .busy      (busy),
    .overrun   (overrun)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic send_vec(input logic [N_OUT-1:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      spk_valid = 1'b1;
      spk_vec   = v;
      step();
    end
    spk_valid = 1'b0;
    spk_vec   = '0;
  endtask

  // Guarantees a fresh low->high edge on done; optionally drives a vector in that same cycle.
  task automatic raise_done(input logic with_vec, input logic [N_OUT-1:0] v);
    done = 1'b0;
    step();
    done      = 1'b1;
    spk_valid = with_vec;
    spk_vec   = with_vec ? v : '0;
    step();
    spk_valid = 1'b0;
    spk_vec   = '0;
  endtask

  // Waits for out_valid (bounded), checks latency and pops the expected result.
  task automatic wait_result(input string tag, input logic [N_OUT-1:0] scan_v, input int scan_n);
    int lat;
    logic [RW-1:0] e;
    lat = 0;
    while (!out_valid && lat < 40) begin
      spk_valid = (lat < scan_n);
      spk_vec   = (lat < scan_n) ? scan_v : '0;
      step();
      lat++;
    end
    spk_valid = 1'b0;
    spk_vec   = '0;
    check({tag, "_latency"}, lat, N_OUT + 1);
    if (exp_q.size() == 0) begin
      check({tag, "_exp_q_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_class"}, 32'(out_class), 32'(e[RW-1:CNT_W]));
      check({tag, "_count"}, 32'(out_count), 32'(e[CNT_W-1:0]));
    end
  endtask

  task automatic accept(input string tag, input logic [IDX_W-1:0] cls, input logic [CNT_W-1:0] cnt);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_xfer_valid"}, 32'(out_valid), 0);
    check({tag, "_xfer_busy"}, 32'(busy), 0);
    check({tag, "_hold_class"}, 32'(out_class), 32'(cls));
    check({tag, "_hold_count"}, 32'(out_count), 32'(cnt));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic seen;
    rst       = 1'b1;
    spk_valid = 1'b0;
    spk_vec   = '0;
    done      = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_out_class", 32'(out_class), 0);
    check("rst_out_count", 32'(out_count), 0);

    // Basic winner: neuron 3 fires every step, neuron 7 on 12 of 20 steps.
    send_vec(10'b00_1000_1000, 12);
    send_vec(10'b00_0000_1000, 8);
    exp_q.push_back({4'd3, 5'd20});
    raise_done(1'b0, '0);
    check("basic_busy", 32'(busy), 1);
    wait_result("basic", '0, 0);
    accept("basic", 4'd3, 5'd20);

    // Tie at 9 between neurons 2 and 5 resolves to the lower index; neuron 8 trails.
    send_vec(10'b01_0010_0100, 8);
    send_vec(10'b00_0010_0100, 1);
    exp_q.push_back({4'd2, 5'd9});
    raise_done(1'b0, '0);
    wait_result("tie", '0, 0);
    accept("tie", 4'd2, 5'd9);

    // Saturation: 40 all-ones vectors pin every count at 31; then backpressure.
    send_vec('1, 40);
    exp_q.push_back({4'd0, 5'd31});
    raise_done(1'b0, '0);
    wait_result("sat", '0, 0);
    for (int i = 0; i < 7; i++) begin
      step();
      check("bp_valid", 32'(out_valid), 1);
      check("bp_class", 32'(out_class), 0);
      check("bp_count", 32'(out_count), 31);
    end
    accept("bp", 4'd0, 5'd31);

    // Second image after transfer: counters must have been cleared.
    send_vec(10'b10_0000_0000, 4);
    exp_q.push_back({4'd9, 5'd4});
    raise_done(1'b0, '0);
    wait_result("img2", '0, 0);
    accept("img2", 4'd9, 5'd4);
    check("img2_overrun", 32'(overrun), 0);

    // Coincident vector counted (3+1), vectors during SCAN discarded and flag overrun.
    send_vec(10'b00_0000_0010, 3);
    exp_q.push_back({4'd1, 5'd4});
    raise_done(1'b1, 10'b00_0000_0010);
    wait_result("ovr", 10'b00_0100_0000, 5);
    check("ovr_overrun", 32'(overrun), 1);
    accept("ovr", 4'd1, 5'd4);

    // done stays high: no new edge, so no second result.
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (out_valid || busy) seen = 1'b1;
    end
    check("held_done_no_result", 32'(seen), 0);
    check("ovr_sticky", 32'(overrun), 1);

    // Reset in the middle of SCAN, then an all-zero image.
    send_vec(10'b00_0001_0000, 3);
    raise_done(1'b0, '0);
    step();
    step();
    check("mid_scan_busy", 32'(busy), 1);
    rst  = 1'b1;
    done = 1'b0;
    step();
    rst = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_overrun", 32'(overrun), 0);
    exp_q.push_back({4'd0, 5'd0});
    raise_done(1'b0, '0);
    wait_result("zero", '0, 0);
    accept("zero", 4'd0, 5'd0);

    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
